spmm_ctrl: RTL and testbench

Sequencer for the SpMM engine: owns the handshakes on the lhs/rhs/out ports and drives the control side of the rhs buffer, the PE and the output buffer. It tracks rhs-buffer and output-buffer occupancy, schedules the rhs load, PE launch and output drain, and generates the `lhs_ready_*` flags, including the weight-stationary and output-stationary modes. It sits beside the PE inside `SpMM` and touches no data.

---
 rtl/spmm_pkg.sv | 22 ++
 rtl/spmm_beat_cnt.sv | 36 +++
 rtl/spmm_ctrl.sv | 138 +++++++++++++
 tb/tb_spmm_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/spmm_pkg.sv
// Shared types and constants for the SpMM engine: matrix geometry, the beat
// index used by the four-row buffer ports, and the lhs issue-mode encoding.
package spmm_pkg;

  localparam int N     = 16;
  localparam int W     = 16;
  localparam int lgN   = $clog2(N);
  localparam int dbLgN = 2 * lgN;
  localparam int BEATS = N / 4;

  typedef logic [W-1:0]   data_t;
  typedef logic [lgN-3:0] beat_t;

  // Issue mode as presented on {lhs_ws, lhs_os}.
  typedef enum logic [1:0] {
    MODE_NS  = 2'b00,
    MODE_OS  = 2'b01,
    MODE_WS  = 2'b10,
    MODE_WOS = 2'b11
  } lhs_mode_e;

endpackage

// File: rtl/spmm_beat_cnt.sv
// Fixed-length beat sequencer for the buffer ports. The beat of the accept
// cycle is 0, and the counter carries beats 1..NUM_BEATS-1 afterwards.
module spmm_beat_cnt
  import spmm_pkg::*;
#(
  parameter int NUM_BEATS = BEATS,
  localparam int BW = $clog2(NUM_BEATS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic          active,
  output logic [BW-1:0] beat,
  output logic          last
);

  assign last = active && (beat == BW'(NUM_BEATS - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      beat   <= '0;
    end else if (start) begin
      active <= 1'b1;
      beat   <= BW'(1);
    end else if (last) begin
      active <= 1'b0;
      beat   <= '0;
    end else if (active) begin
      beat <= beat + 1'b1;
    end
  end

endmodule

// File: rtl/spmm_ctrl.sv
// SpMM sequencer: handshakes on the lhs/rhs/out ports, occupancy flags for the
// rhs and output buffers, and control strobes for rhs load, PE launch and drain.
module spmm_ctrl #(
  parameter int N        = 16,
  parameter int PE_DELAY = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   lhs_ready_ns,
  output logic                   lhs_ready_ws,
  output logic                   lhs_ready_os,
  output logic                   lhs_ready_wos,
  input  logic                   lhs_start,
  input  logic                   lhs_ws,
  input  logic                   lhs_os,
  output logic                   rhs_ready,
  input  logic                   rhs_start,
  output logic                   out_ready,
  input  logic                   out_start,
  output logic                   rhs_wr_en,
  output logic [$clog2(N)-3:0]   rhs_wr_beat,
  output logic                   pe_start,
  output logic                   out_wr_en,
  output logic                   out_acc,
  output logic                   out_rd_en,
  output logic [$clog2(N)-3:0]   out_rd_beat,
  output logic                   busy
);

  import spmm_pkg::*;

  localparam int CW = $clog2(PE_DELAY + 1);

  logic          alive;
  logic          rhs_valid;
  logic          out_valid;
  logic          ws_q;
  logic          os_q;
  logic [CW-1:0] pe_cnt;

  logic          loading;
  logic          computing;
  logic          draining;
  logic          rhs_last;
  logic          out_last;
  logic          rhs_go;
  logic          lhs_go;
  logic          out_go;
  logic          pe_done;
  logic          common_ready;
  logic          mode_ready;
  lhs_mode_e     mode;

  assign computing    = (pe_cnt != '0);
  assign pe_done      = (pe_cnt == CW'(1));
  assign common_ready = rhs_valid && !computing && !draining;

  assign lhs_ready_ns  = common_ready && !out_valid;
  assign lhs_ready_ws  = common_ready && !out_valid;
  assign lhs_ready_os  = common_ready && out_valid;
  assign lhs_ready_wos = common_ready && out_valid;

  // alive keeps rhs_ready low while reset is held, so every output reads 0.
  assign rhs_ready = alive && !rhs_valid && !loading;
  assign out_ready = out_valid && !computing && !draining;

  assign mode = lhs_mode_e'({lhs_ws, lhs_os});

  // NOTE: every always_comb output is given a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    mode_ready = 1'b0;
    case (mode)
      MODE_NS:  mode_ready = lhs_ready_ns;
      MODE_WS:  mode_ready = lhs_ready_ws;
      MODE_OS:  mode_ready = lhs_ready_os;
      MODE_WOS: mode_ready = lhs_ready_wos;
      default:  mode_ready = 1'b0;
    endcase
  end

  assign rhs_go = rhs_start && rhs_ready;
  assign lhs_go = lhs_start && mode_ready;
  assign out_go = out_start && out_ready;

  assign pe_start  = lhs_go;
  assign out_wr_en = pe_done;
  assign out_acc   = pe_done && os_q;
  assign rhs_wr_en = rhs_go || loading;
  assign out_rd_en = out_go || draining;
  assign busy      = loading || computing || draining;

  spmm_beat_cnt #(.NUM_BEATS(N / 4)) u_rhs_cnt (
    .clock  (clock),
    .reset  (reset),
    .start  (rhs_go),
    .active (loading),
    .beat   (rhs_wr_beat),
    .last   (rhs_last)
  );

  spmm_beat_cnt #(.NUM_BEATS(N / 4)) u_out_cnt (
    .clock  (clock),
    .reset  (reset),
    .start  (out_go),
    .active (draining),
    .beat   (out_rd_beat),
    .last   (out_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alive     <= 1'b0;
      rhs_valid <= 1'b0;
      out_valid <= 1'b0;
      ws_q      <= 1'b0;
      os_q      <= 1'b0;
      pe_cnt    <= '0;
    end else begin
      alive <= 1'b1;
      if (rhs_last) rhs_valid <= 1'b1;
      if (lhs_go) begin
        pe_cnt <= CW'(PE_DELAY);
        ws_q   <= lhs_ws;
        os_q   <= lhs_os;
      end else if (computing) begin
        pe_cnt <= pe_cnt - 1'b1;
      end
      // Result lands this cycle; a non-stationary rhs is consumed with it.
      if (pe_done) begin
        out_valid <= 1'b1;
        if (!ws_q) rhs_valid <= 1'b0;
      end
      if (out_last) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spmm_ctrl.sv
// Self-checking bench for spmm_ctrl: directed scenarios then random traffic,
// compared every cycle against a timestamp-based model of the handshakes.
module tb_spmm_ctrl;

  localparam int N        = 16;
  localparam int PE_DELAY = 6;
  localparam int BEATS    = N / 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       lhs_ready_ns, lhs_ready_ws, lhs_ready_os, lhs_ready_wos;
  logic       lhs_start = 1'b0, lhs_ws = 1'b0, lhs_os = 1'b0;
  logic       rhs_ready, rhs_start = 1'b0;
  logic       out_ready, out_start = 1'b0;
  logic       rhs_wr_en, pe_start, out_wr_en, out_acc, out_rd_en, busy;
  logic [1:0] rhs_wr_beat, out_rd_beat;

  always #5 clock = ~clock;

  spmm_ctrl #(.N(N), .PE_DELAY(PE_DELAY)) dut (
    .clock         (clock),
    .reset         (reset),
    .lhs_ready_ns  (lhs_ready_ns),
    .lhs_ready_ws  (lhs_ready_ws),
    .lhs_ready_os  (lhs_ready_os),
    .lhs_ready_wos (lhs_ready_wos),
    .lhs_start     (lhs_start),
    .lhs_ws        (lhs_ws),
    .lhs_os        (lhs_os),
    .rhs_ready     (rhs_ready),
    .rhs_start     (rhs_start),
    .out_ready     (out_ready),
    .out_start     (out_start),
    .rhs_wr_en     (rhs_wr_en),
    .rhs_wr_beat   (rhs_wr_beat),
    .pe_start      (pe_start),
    .out_wr_en     (out_wr_en),
    .out_acc       (out_acc),
    .out_rd_en     (out_rd_en),
    .out_rd_beat   (out_rd_beat),
    .busy          (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: when each transaction was accepted, plus the two occupancy flags.
  int load_t, issue_t, drain_t;
  bit rv, ov, m_ws, m_os, m_alive;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    load_t  = -1000;
    issue_t = -1000;
    drain_t = -1000;
    rv = 1'b0; ov = 1'b0; m_ws = 1'b0; m_os = 1'b0; m_alive = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy_ns"},  32'(lhs_ready_ns),  0);
    check({tag, "_rdy_ws"},  32'(lhs_ready_ws),  0);
    check({tag, "_rdy_os"},  32'(lhs_ready_os),  0);
    check({tag, "_rdy_wos"}, 32'(lhs_ready_wos), 0);
    check({tag, "_rhs_rdy"}, 32'(rhs_ready),     0);
    check({tag, "_out_rdy"}, 32'(out_ready),     0);
    check({tag, "_wr_en"},   32'(rhs_wr_en),     0);
    check({tag, "_wr_beat"}, 32'(rhs_wr_beat),   0);
    check({tag, "_pe"},      32'(pe_start),      0);
    check({tag, "_owr"},     32'(out_wr_en),     0);
    check({tag, "_acc"},     32'(out_acc),       0);
    check({tag, "_rd_en"},   32'(out_rd_en),     0);
    check({tag, "_rd_beat"}, 32'(out_rd_beat),   0);
    check({tag, "_busy"},    32'(busy),          0);
  endtask

  // Assert reset (at once, or at the next falling edge), check that every
  // output is 0 even with all starts raised, then release and re-enter.
  task automatic do_reset(input bit now);
    if (!now) @(negedge clock);
    reset = 1'b0;
    model_clear();
    rhs_start = 1'b1; lhs_start = 1'b1; out_start = 1'b1;
    lhs_ws = 1'b0; lhs_os = 1'b0;
    #1;
    check_all_zero("rst");
    repeat (2) @(negedge clock);
    rhs_start = 1'b0; lhs_start = 1'b0; out_start = 1'b0;
    reset = 1'b1;
    #1;
    check("rel_rhs_rdy", 32'(rhs_ready), 0);
    @(posedge clock);
    cyc++;
    m_alive = 1'b1;
  endtask

  task automatic step(input bit rs, input bit ls, input bit lws, input bit los, input bit ds);
    bit loading, comp, drn, common, r_ns, r_os, rrdy, ordy, mrdy;
    bit rhs_go, lhs_go, out_go, wr, rd, pw;
    @(negedge clock);
    if (cyc == load_t + BEATS) rv = 1'b1;
    if (cyc == issue_t + PE_DELAY + 1) begin
      ov = 1'b1;
      if (!m_ws) rv = 1'b0;
    end
    if (cyc == drain_t + BEATS) ov = 1'b0;

    loading = (cyc > load_t)  && (cyc < load_t + BEATS);
    comp    = (cyc > issue_t) && (cyc <= issue_t + PE_DELAY);
    drn     = (cyc > drain_t) && (cyc < drain_t + BEATS);
    common  = rv && !comp && !drn;
    r_ns    = common && !ov;
    r_os    = common && ov;
    rrdy    = m_alive && !rv && !loading;
    ordy    = ov && !comp && !drn;
    mrdy    = los ? r_os : r_ns;
    rhs_go  = rs && rrdy;
    lhs_go  = ls && mrdy;
    out_go  = ds && ordy;

    rhs_start = rs; lhs_start = ls; lhs_ws = lws; lhs_os = los; out_start = ds;
    #1;
    check("rhs_ready",     32'(rhs_ready),     32'(rrdy));
    check("lhs_ready_ns",  32'(lhs_ready_ns),  32'(r_ns));
    check("lhs_ready_ws",  32'(lhs_ready_ws),  32'(r_ns));
    check("lhs_ready_os",  32'(lhs_ready_os),  32'(r_os));
    check("lhs_ready_wos", 32'(lhs_ready_wos), 32'(r_os));
    check("out_ready",     32'(out_ready),     32'(ordy));
    check("busy",          32'(busy),          32'(loading || comp || drn));

    if (rhs_go) load_t = cyc;
    if (lhs_go) begin issue_t = cyc; m_ws = lws; m_os = los; end
    if (out_go) drain_t = cyc;
    wr = (cyc >= load_t)  && (cyc < load_t + BEATS);
    rd = (cyc >= drain_t) && (cyc < drain_t + BEATS);
    pw = (cyc == issue_t + PE_DELAY);

    check("pe_start",    32'(pe_start),    32'(lhs_go));
    check("rhs_wr_en",   32'(rhs_wr_en),   32'(wr));
    check("rhs_wr_beat", 32'(rhs_wr_beat), wr ? 32'(cyc - load_t) : 0);
    check("out_wr_en",   32'(out_wr_en),   32'(pw));
    check("out_acc",     32'(out_acc),     32'(pw && m_os));
    check("out_rd_en",   32'(out_rd_en),   32'(rd));
    check("out_rd_beat", 32'(out_rd_beat), rd ? 32'(cyc - drain_t) : 0);

    @(posedge clock);
    cyc++;
    m_alive = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    model_clear();
    do_reset(1'b1);

    // Load, then a non-stationary issue that consumes the rhs.
    idle(1);
    step(1, 0, 0, 0, 0); idle(3);
    step(0, 1, 0, 0, 0); idle(PE_DELAY + 1);
    step(0, 0, 0, 0, 1); idle(BEATS);

    // Illegal os, ws issue, illegal ns, accumulating os.
    step(1, 0, 0, 0, 0); idle(3);
    step(0, 1, 0, 1, 0);
    step(0, 1, 1, 0, 0); idle(PE_DELAY + 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0); idle(PE_DELAY + 1);
    step(0, 0, 0, 0, 1); idle(BEATS);

    // ws then wos keep the rhs; ns becomes ready right at drain end.
    step(1, 0, 0, 0, 0); idle(3);
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 0, 0); idle(PE_DELAY + 1);
    step(0, 1, 1, 1, 0); idle(PE_DELAY + 1);
    step(0, 0, 0, 0, 1); idle(BEATS);
    step(0, 1, 0, 0, 0); idle(PE_DELAY + 1);

    // Overlapped load and drain, reset during their second beat.
    step(1, 0, 0, 0, 1);
    #2;
    check("ovl_wr_en",   32'(rhs_wr_en),   1);
    check("ovl_wr_beat", 32'(rhs_wr_beat), 1);
    check("ovl_rd_en",   32'(out_rd_en),   1);
    check("ovl_rd_beat", 32'(out_rd_beat), 1);
    do_reset(1'b1);
    idle(1);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) do_reset(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
